axilite_arb: RTL

// - Shares one AXI4-Lite slave port (e.g. an axilite2umi bridge) between two AXI4-Lite

---
 rtl/axilite_arb.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axilite_arb.sv
// Two-master to one-slave AXI4-Lite arbiter. Write (AW/W/B) and read (AR/R) paths
// arbitrate independently, round-robin, one outstanding transaction each.
module axilite_arb #(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic              clk,
    input  logic              nreset,
    // master 0
    input  logic [AW-1:0]     s0_axi_awaddr,
    input  logic [2:0]        s0_axi_awprot,
    input  logic              s0_axi_awvalid,
    output logic              s0_axi_awready,
    input  logic [DW-1:0]     s0_axi_wdata,
    input  logic [DW/8-1:0]   s0_axi_wstrb,
    input  logic              s0_axi_wvalid,
    output logic              s0_axi_wready,
    output logic [1:0]        s0_axi_bresp,
    output logic              s0_axi_bvalid,
    input  logic              s0_axi_bready,
    input  logic [AW-1:0]     s0_axi_araddr,
    input  logic [2:0]        s0_axi_arprot,
    input  logic              s0_axi_arvalid,
    output logic              s0_axi_arready,
    output logic [DW-1:0]     s0_axi_rdata,
    output logic [1:0]        s0_axi_rresp,
    output logic              s0_axi_rvalid,
    input  logic              s0_axi_rready,
    // master 1
    input  logic [AW-1:0]     s1_axi_awaddr,
    input  logic [2:0]        s1_axi_awprot,
    input  logic              s1_axi_awvalid,
    output logic              s1_axi_awready,
    input  logic [DW-1:0]     s1_axi_wdata,
    input  logic [DW/8-1:0]   s1_axi_wstrb,
    input  logic              s1_axi_wvalid,
    output logic              s1_axi_wready,
    output logic [1:0]        s1_axi_bresp,
    output logic              s1_axi_bvalid,
    input  logic              s1_axi_bready,
    input  logic [AW-1:0]     s1_axi_araddr,
    input  logic [2:0]        s1_axi_arprot,
    input  logic              s1_axi_arvalid,
    output logic              s1_axi_arready,
    output logic [DW-1:0]     s1_axi_rdata,
    output logic [1:0]        s1_axi_rresp,
    output logic              s1_axi_rvalid,
    input  logic              s1_axi_rready,
    // shared slave
    output logic [AW-1:0]     m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DW-1:0]     m_axi_wdata,
    output logic [DW/8-1:0]   m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [AW-1:0]     m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DW-1:0]     m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    typedef enum logic [1:0] {WIDLE, WADDR, WRESP} wstate_t;
    typedef enum logic [1:0] {RIDLE, RADDR, RRESP} rstate_t;

    wstate_t wstate_q, wstate_d;
    rstate_t rstate_q, rstate_d;
    logic    wgnt_q, wgnt_d, wptr_q, wptr_d;
    logic    aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic    rgnt_q, rgnt_d, rptr_q, rptr_d;

    logic              aw_ok, w_ok;
    logic [AW-1:0]     sel_awaddr, sel_araddr;
    logic [2:0]        sel_awprot, sel_arprot;
    logic [DW-1:0]     sel_wdata;
    logic [DW/8-1:0]   sel_wstrb;
    logic              sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;

    assign sel_awaddr  = wgnt_q ? s1_axi_awaddr  : s0_axi_awaddr;
    assign sel_awprot  = wgnt_q ? s1_axi_awprot  : s0_axi_awprot;
    assign sel_awvalid = wgnt_q ? s1_axi_awvalid : s0_axi_awvalid;
    assign sel_wdata   = wgnt_q ? s1_axi_wdata   : s0_axi_wdata;
    assign sel_wstrb   = wgnt_q ? s1_axi_wstrb   : s0_axi_wstrb;
    assign sel_wvalid  = wgnt_q ? s1_axi_wvalid  : s0_axi_wvalid;
    assign sel_bready  = wgnt_q ? s1_axi_bready  : s0_axi_bready;
    assign sel_araddr  = rgnt_q ? s1_axi_araddr  : s0_axi_araddr;
    assign sel_arprot  = rgnt_q ? s1_axi_arprot  : s0_axi_arprot;
    assign sel_arvalid = rgnt_q ? s1_axi_arvalid : s0_axi_arvalid;
    assign sel_rready  = rgnt_q ? s1_axi_rready  : s0_axi_rready;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wstate_q  <= WIDLE;
            wgnt_q    <= 1'b0;
            wptr_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rstate_q  <= RIDLE;
            rgnt_q    <= 1'b0;
            rptr_q    <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            wgnt_q    <= wgnt_d;
            wptr_q    <= wptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rstate_q  <= rstate_d;
            rgnt_q    <= rgnt_d;
            rptr_q    <= rptr_d;
        end
    end

    // Write path: AW and W may finish in either order; done flags mask re-issue.
    always_comb begin
        wstate_d       = wstate_q;
        wgnt_d         = wgnt_q;
        wptr_d         = wptr_q;
        aw_done_d      = aw_done_q;
        w_done_d       = w_done_q;
        aw_ok          = 1'b0;
        w_ok           = 1'b0;
        m_axi_awaddr   = '0;
        m_axi_awprot   = '0;
        m_axi_awvalid  = 1'b0;
        m_axi_wdata    = '0;
        m_axi_wstrb    = '0;
        m_axi_wvalid   = 1'b0;
        m_axi_bready   = 1'b0;
        s0_axi_awready = 1'b0;
        s1_axi_awready = 1'b0;
        s0_axi_wready  = 1'b0;
        s1_axi_wready  = 1'b0;
        s0_axi_bresp   = 2'b00;
        s1_axi_bresp   = 2'b00;
        s0_axi_bvalid  = 1'b0;
        s1_axi_bvalid  = 1'b0;
        case (wstate_q)
            WIDLE: begin
                if (s0_axi_awvalid || s1_axi_awvalid) begin
                    wstate_d = WADDR;
                    if (s0_axi_awvalid && s1_axi_awvalid) begin
                        wgnt_d = wptr_q;
                        wptr_d = ~wptr_q;
                    end else begin
                        wgnt_d = s1_axi_awvalid;
                    end
                end
            end
            WADDR: begin
                m_axi_awaddr  = sel_awaddr;
                m_axi_awprot  = sel_awprot;
                m_axi_awvalid = sel_awvalid & ~aw_done_q;
                m_axi_wdata   = sel_wdata;
                m_axi_wstrb   = sel_wstrb;
                m_axi_wvalid  = sel_wvalid & ~w_done_q;
                aw_ok         = m_axi_awready & ~aw_done_q;
                w_ok          = m_axi_wready & ~w_done_q;
                if (wgnt_q) begin
                    s1_axi_awready = aw_ok;
                    s1_axi_wready  = w_ok;
                end else begin
                    s0_axi_awready = aw_ok;
                    s0_axi_wready  = w_ok;
                end
                if (aw_ok && sel_awvalid) aw_done_d = 1'b1;
                if (w_ok && sel_wvalid)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) wstate_d = WRESP;
            end
            WRESP: begin
                m_axi_bready = sel_bready;
                if (wgnt_q) begin
                    s1_axi_bvalid = m_axi_bvalid;
                    s1_axi_bresp  = m_axi_bresp;
                end else begin
                    s0_axi_bvalid = m_axi_bvalid;
                    s0_axi_bresp  = m_axi_bresp;
                end
                if (m_axi_bvalid && sel_bready) begin
                    wstate_d  = WIDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: wstate_d = WIDLE;
        endcase
    end

    always_comb begin
        rstate_d       = rstate_q;
        rgnt_d         = rgnt_q;
        rptr_d         = rptr_q;
        m_axi_araddr   = '0;
        m_axi_arprot   = '0;
        m_axi_arvalid  = 1'b0;
        m_axi_rready   = 1'b0;
        s0_axi_arready = 1'b0;
        s1_axi_arready = 1'b0;
        s0_axi_rdata   = '0;
        s1_axi_rdata   = '0;
        s0_axi_rresp   = 2'b00;
        s1_axi_rresp   = 2'b00;
        s0_axi_rvalid  = 1'b0;
        s1_axi_rvalid  = 1'b0;
        case (rstate_q)
            RIDLE: begin
                if (s0_axi_arvalid || s1_axi_arvalid) begin
                    rstate_d = RADDR;
                    if (s0_axi_arvalid && s1_axi_arvalid) begin
                        rgnt_d = rptr_q;
                        rptr_d = ~rptr_q;
                    end else begin
                        rgnt_d = s1_axi_arvalid;
                    end
                end
            end
            RADDR: begin
                m_axi_araddr  = sel_araddr;
                m_axi_arprot  = sel_arprot;
                m_axi_arvalid = sel_arvalid;
                if (rgnt_q) s1_axi_arready = m_axi_arready;
                else        s0_axi_arready = m_axi_arready;
                if (sel_arvalid && m_axi_arready) rstate_d = RRESP;
            end
            RRESP: begin
                m_axi_rready = sel_rready;
                if (rgnt_q) begin
                    s1_axi_rvalid = m_axi_rvalid;
                    s1_axi_rdata  = m_axi_rdata;
                    s1_axi_rresp  = m_axi_rresp;
                end else begin
                    s0_axi_rvalid = m_axi_rvalid;
                    s0_axi_rdata  = m_axi_rdata;
                    s0_axi_rresp  = m_axi_rresp;
                end
                if (m_axi_rvalid && sel_rready) rstate_d = RIDLE;
            end
            default: rstate_d = RIDLE;
        endcase
    end

endmodule
